l2_flatten: RTL

//   Layer-2 flatten stage, directly downstream of the convolution/max-pool engine.

---
 rtl/l2_flatten.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/l2_flatten.sv
// Layer-2 flatten stage: interleaves the two layer-1 pooled maps element by element
// into layer-2 memory over the shared cdata/caddr/csel bus, one bus access per clock.
module l2_flatten #(
    parameter int MAP_N = 1024,
    parameter int DW    = 20,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int IW = $clog2(MAP_N);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_WR0  = 3'd2;
    localparam logic [2:0] S_RD1  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_K0   = 3'b011;
    localparam logic [2:0] SEL_K1   = 3'b100;
    localparam logic [2:0] SEL_L2   = 3'b101;

    localparam logic [IW-1:0] IDX_LAST = IW'(MAP_N - 1);

    logic [2:0]    state_r;
    logic [IW-1:0] idx_r;
    logic          busy_r;
    logic          done_r;
    logic          crd_r;
    logic          cwr_r;
    logic [2:0]    csel_r;
    logic [AW-1:0] caddr_rd_r;
    logic [AW-1:0] caddr_wr_r;
    logic [DW-1:0] cdata_wr_r;

    logic [2:0]    state_nxt_s;
    logic [IW-1:0] idx_nxt_s;
    logic          busy_nxt_s;
    logic          done_nxt_s;
    logic          crd_nxt_s;
    logic          cwr_nxt_s;
    logic [2:0]    csel_nxt_s;

    // Next-state and element index; idx is cleared while idle so every run starts at element 0.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            S_IDLE: begin
                idx_nxt_s = '0;
                if (start) begin
                    state_nxt_s = S_RD0;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD0: state_nxt_s = S_WR0;
            S_WR0: state_nxt_s = S_RD1;
            S_RD1: state_nxt_s = S_WR1;
            S_WR1: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = S_FIN;
                end else begin
                    idx_nxt_s   = idx_r + IW'(1);
                    state_nxt_s = S_RD0;
                end
            end
            S_FIN:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so strobes and csel are registered with it.
    always_comb begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
        crd_nxt_s  = 1'b0;
        cwr_nxt_s  = 1'b0;
        csel_nxt_s = SEL_NONE;
        case (state_nxt_s)
            S_IDLE: busy_nxt_s = 1'b0;
            S_RD0: begin
                crd_nxt_s  = 1'b1;
                csel_nxt_s = SEL_K0;
            end
            S_WR0: begin
                cwr_nxt_s  = 1'b1;
                csel_nxt_s = SEL_L2;
            end
            S_RD1: begin
                crd_nxt_s  = 1'b1;
                csel_nxt_s = SEL_K1;
            end
            S_WR1: begin
                cwr_nxt_s  = 1'b1;
                csel_nxt_s = SEL_L2;
            end
            S_FIN:   done_nxt_s = 1'b1;
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // State, index and registered bus outputs; addresses hold while their strobe is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            idx_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            crd_r      <= 1'b0;
            cwr_r      <= 1'b0;
            csel_r     <= SEL_NONE;
            caddr_rd_r <= '0;
            caddr_wr_r <= '0;
            cdata_wr_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            crd_r   <= crd_nxt_s;
            cwr_r   <= cwr_nxt_s;
            csel_r  <= csel_nxt_s;
            if ((state_nxt_s == S_RD0) || (state_nxt_s == S_RD1)) begin
                caddr_rd_r <= AW'(idx_nxt_s);
            end
            if (state_nxt_s == S_WR0) begin
                caddr_wr_r <= AW'({idx_nxt_s, 1'b0});
            end
            if (state_nxt_s == S_WR1) begin
                caddr_wr_r <= AW'({idx_nxt_s, 1'b1});
            end
            // cdata_wr doubles as the holding register: read data lands here as the read cycle ends.
            if ((state_r == S_RD0) || (state_r == S_RD1)) begin
                cdata_wr_r <= cdata_rd;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign crd      = crd_r;
    assign cwr      = cwr_r;
    assign csel     = csel_r;
    assign caddr_rd = caddr_rd_r;
    assign caddr_wr = caddr_wr_r;
    assign cdata_wr = cdata_wr_r;

endmodule
